ahb_sram_slave: RTL
===================

Name: ahb_sram_slave

Overview:
- AHB-lite slave that terminates the slave side of the simple_ahb bus in chip_top.
- Provides a word-organised on-chip SRAM with byte, halfword and word access.
- Inserts a programmable number of wait states per transfer and returns two-cycle ERROR responses for illegal accesses.
- Sits directly downstream of the bus slave port and consumes the address/control and write data driven by the master.

Parameters:
DEPTH, 256, number of 32-bit words in the SRAM; power of two, minimum 4
WAIT_STATES, 0, wait cycles (hreadyout=0) inserted in every OKAY data phase; range 0..15
AW, $clog2(DEPTH), word-index width (derived; not overridden)

Ports:
hclk  input  1  bus clock; all state changes on its rising edge
hresetN  input  1  asynchronous active-low reset
hsel  input  1  slave select from decoder
haddr  input  32  byte address (address phase)
htrans  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  input  1  1=write, 0=read (address phase)
hsize  input  3  transfer size: 0 byte, 1 halfword, 2 word
hwdata  input  32  write data (data phase)
hready  input  1  bus-level ready; the previous transfer completes when high
hreadyout  output  1  slave ready; 0 stalls the current data phase
hresp  output  1  0 OKAY, 1 ERROR
hrdata  output  32  read data; valid when hreadyout=1 in a read data phase

Behaviour:
Interface:
- One clock (hclk); reset hresetN is asynchronous, active-low.

Reset:
- Outputs: hreadyout=1, hresp=0, hrdata=0.
- FSM goes to IDLE; wait counter = 0.
- SRAM contents are not reset (inferred RAM).
- Reset asserted mid data phase aborts the transfer; a pending write is NOT committed.

Address-phase accept:
- Condition: hsel & hready & htrans[1].
- Registers haddr, hwrite, hsize.
- IDLE or BUSY with hsel=1 gets a zero-wait OKAY and is otherwise ignored.

Error check (at accept):
- Error if hsize>2.
- Error if misaligned: hsize=1 with haddr[0]!=0, or hsize=2 with haddr[1:0]!=0.
- Error if out of range: haddr[31:AW+2]!=0.

FSM states:
- IDLE: hreadyout=1, hresp=0. Accept of a legal transfer goes to WAIT when WAIT_STATES>0, else DATA. Accept of an illegal transfer goes to ERR1.
- WAIT: hreadyout=0, hresp=0. Counter loads WAIT_STATES-1 on entry and decrements each cycle; goes to DATA when the counter is 0.
- DATA: hreadyout=1, hresp=0; the final data-phase cycle. A new accept in the same cycle (pipelined back-to-back) re-enters WAIT, DATA or ERR1 per the rules above; otherwise returns to IDLE.
- ERR1: hreadyout=0, hresp=1. Always goes to ERR2.
- ERR2: hreadyout=1, hresp=1. A new accept is honoured as in DATA; otherwise returns to IDLE.

Data path:
- Write commit: on the rising edge ending the DATA cycle, using the hwdata sampled in that cycle.
- Byte lanes: hsize=0 writes lane haddr[1:0]; hsize=1 writes lanes {haddr[1],0} and {haddr[1],1}; hsize=2 writes all 4 lanes. Other lanes are unchanged.
- Reads: hrdata = full word mem[addr_q[AW+1:2]] during a read DATA cycle, and 0 in every other cycle. Lane extraction is left to the master.
- Latency: a read or write completes WAIT_STATES+1 cycles after the accepting address phase.
- Read-after-write to the same word in consecutive transfers returns the new data; no forwarding is needed because the commit precedes the next DATA cycle.
- Errored transfers never modify the SRAM; hrdata=0 during ERR1 and ERR2.
- Address phases are sampled only while hready=1. This block never accepts during WAIT or ERR1, since its own hreadyout=0 drives hready low.
- An accept with hsel=0 and hready=1 while in DATA or ERR2 returns the FSM to IDLE.

Test Plan:
- Reset then idle: hresetN low 3 cycles, release, htrans=00 -> hreadyout=1, hresp=0, hrdata=0 for every cycle.
- Word write/read, WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> read data phase one cycle after its address phase, hrdata=0xDEADBEEF, hresp=0.
- Byte/halfword lanes: word write 0x00000000 to 0x20; byte write 0xAA to 0x21 (hwdata=0x0000AA00); halfword write 0x1234 to 0x22 (hwdata=0x12340000); word read 0x20 -> hrdata=0x1234AA00.
- Wait states, WAIT_STATES=3: read 0x04 -> hreadyout low exactly 3 cycles then high with data; next pipelined transfer is accepted only in the hreadyout=1 cycle.
- Errors, DEPTH=256: word read 0x400 (out of range), halfword at 0x03 (misaligned), hsize=3 -> each gives ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1); a prior write to 0x00 reads back unchanged.
- Reset mid-operation, WAIT_STATES=3: write 0x55555555 to 0x08 and assert hresetN in the second WAIT cycle -> outputs return to reset values immediately; a later read of 0x08 returns the old value, not 0x55555555.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//   AHB-lite slave fronting a word-organised on-chip SRAM. Supports byte,
//   halfword and word transfers, inserts WAIT_STATES wait cycles in every
//   OKAY data phase and answers illegal accesses with a two-cycle ERROR.
//
// Handshake: an address phase is taken when hsel & hready & htrans[1] while
//   the slave sits in IDLE, DATA or ERR2. A data phase ends on the first
//   cycle with hreadyout=1. hreadyout=0 holds the bus, so no new address
//   phase can be taken in WAIT or ERR1.
//
// Ports:
//   hclk, hresetN          clock, asynchronous active-low reset
//   hsel, haddr, htrans,   address/control from the master (address phase)
//   hwrite, hsize
//   hwdata                 write data (data phase)
//   hready                 bus-level ready (previous transfer completes)
//   hreadyout, hresp       slave ready / response (0 OKAY, 1 ERROR)
//   hrdata                 full read word in a read DATA cycle, else 0
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetN,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [1:0]      size_q, size_d;
  logic            hreadyout_q, hreadyout_d;
  logic            hresp_q, hresp_d;

  logic [31:0]     mem [DEPTH];

  logic            can_accept;
  logic            accept;
  logic            size_err;
  logic            align_err;
  logic            range_err;
  logic            addr_err;
  logic [AW-1:0]   widx;
  logic [3:0]      byte_en;

  // Legality of the transfer currently on the address bus.
  always_comb begin
    size_err  = (hsize > 3'd2);
    align_err = ((hsize == 3'd1) && haddr[0]) ||
                ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    range_err = ((haddr >> (AW + 2)) != 32'd0);
    addr_err  = size_err || align_err || range_err;
  end

  // Only the states that drive hreadyout=1 can overlap a new address phase.
  always_comb begin
    can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    accept     = can_accept && hsel && hready && htrans[1];
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    size_d     = size_q;
    case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = ST_DATA;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 fall back to IDLE unless a transfer is taken.
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = haddr[AW+1:0];
          write_d = hwrite;
          size_d  = hsize[1:0];
          if (addr_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
    hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
  end

  always_ff @(posedge hclk or negedge hresetN) begin
    if (!hresetN) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign widx = addr_q[AW+1:2];

  // Lanes touched by the transfer in its data phase; only legal sizes
  // ever reach DATA, so size 3 never needs a value here.
  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      2'd0:    byte_en = 4'b0001 << addr_q[1:0];
      2'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Commit happens on the edge that closes the DATA cycle. Reset forces the
  // FSM out of DATA, so a write interrupted by reset is never committed.
  always_ff @(posedge hclk) begin
    if ((state_q == ST_DATA) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[widx][b*8 +: 8] <= hwdata[b*8 +: 8];
      end
    end
  end

  assign hrdata    = ((state_q == ST_DATA) && !write_q) ? mem[widx] : 32'd0;
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;

endmodule
